poly_dl_ctrl: RTL and testbench
===============================

# poly_dl_ctrl

Download and boot sequencer for the Poly-Play core. It sits between the HPS `ioctl` download stream and the PolyPlay ROM write port. It routes index-0 bytes into ROM and captures the index-1 title number. It also holds the CPU in reset from the start of a download until the image has been verified and a post-load hold time has elapsed. It replaces the ad-hoc `dn_wr`/`tno` glue in the top level with one controlled state machine.

## Interface
Parameters:
- `ROM_BYTES`, default 32768: expected image size in bytes. Valid range is 1..65536.
- `HOLD_CYCLES`, default 16: number of clk_sys cycles the CPU stays in reset after a good load or an external reset. Must be at least 1.

Ports:
- `clk_sys`  in  1  system clock. All logic is in this single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ext_reset`  in  1  OSD/user reset request, synchronous level.
- `ioctl_download`  in  1  high while the HPS transfer is active.
- `ioctl_index`  in  8  transfer index. 0 = ROM image, 1 = title number.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `rom_we`  out  1  ROM write strobe.
- `rom_addr`  out  16  ROM write address.
- `rom_data`  out  8  ROM write data.
- `tno`  out  8  captured title number.
- `cpu_reset`  out  1  active-high reset to PolyPlay `reset_sig`.
- `rom_ready`  out  1  high only in the RUN state.
- `dl_error`  out  1  set on a bad load, held until the next download starts.
- `chksum`  out  8  modulo-256 sum of accepted ROM bytes.

## Operation
- The state register has six states: IDLE, LOAD, CHECK, HOLD, RUN, ERROR.
- `cpu_reset` = (state != RUN), decoded directly from the state register with no extra register stage. `rom_ready` = (state == RUN).
- `dl_prev` is a register holding `ioctl_download` from the previous cycle. Rise = `ioctl_download & ~dl_prev`. Fall = `~ioctl_download & dl_prev`.
- A rise in any state moves the FSM to LOAD. On entry to LOAD:
  - `cnt` (17 bits) is cleared.
  - `chksum` is cleared.
  - the overflow flag is cleared.
  - `dl_error` is cleared.
- Writes in LOAD, and in the cycle in which the fall is detected:
  - Index 0 with `ioctl_addr` < `ROM_BYTES`: the byte is accepted. `rom_we`, `rom_addr` = `ioctl_addr[15:0]` and `rom_data` are registered. `cnt` increments. `chksum` = `chksum + ioctl_dout` (mod 256).
  - Index 0 with `ioctl_addr` >= `ROM_BYTES`: the byte is dropped and the overflow flag is set.
  - Index 1: `tno` <= `ioctl_dout`. The last write wins and no `rom_we` is generated.
  - Any other index: ignored.
- Fall while in LOAD → CHECK.
- CHECK lasts one cycle:
  - If overflow is set, or `cnt` != `ROM_BYTES`, go to ERROR and set `dl_error`.
  - Otherwise go to HOLD with the hold counter cleared.
- HOLD: the hold counter increments every cycle. When it equals `HOLD_CYCLES-1`, the FSM moves to RUN.
- RUN: `ext_reset` high moves the FSM to HOLD with the counter cleared. `tno`, `chksum` and ROM contents are preserved.
- ERROR: the CPU stays in reset. Only a new download (rise) leaves this state. `ext_reset` is ignored.
- IDLE: entered only by `reset_n`. It waits for a rise. `ext_reset` is ignored.
- `ext_reset` in LOAD or CHECK is ignored.
- A rise in HOLD, RUN or ERROR aborts the current state and enters LOAD.
- `ioctl_wr` strobes outside LOAD, except the fall cycle, are ignored.

## Timing
- Reset (`reset_n` low, asynchronous) values:
  - state = IDLE
  - `cpu_reset` = 1
  - `rom_ready` = 0
  - `rom_we` = 0
  - `rom_addr` = 0
  - `rom_data` = 0
  - `tno` = 0
  - `dl_error` = 0
  - `chksum` = 0
  - counters = 0
  - `dl_prev` = 0
- `reset_n` asserted mid-load discards everything. After release the FSM waits for a new rise.
- A write strobe at edge N gives `rom_we` high for exactly the cycle N+1, with matching `rom_addr`/`rom_data`. Back-to-back strobes give back-to-back `rom_we` pulses.
- `tno` updates at the edge following the index-1 strobe.
- Edge detection adds one cycle: `ioctl_download` rising before edge E means state = LOAD after edge E+1.
- `cpu_reset` falls `HOLD_CYCLES`+2 edges after the fall is registered (fall register edge, then CHECK, then HOLD).
- A rise that coincides with a write strobe is handled as follows: the rise takes priority for state clearing and the write is dropped.

## Test plan
- Load 32768 index-0 bytes (data = addr[7:0]), then drop `ioctl_download` → 32768 `rom_we` pulses, `chksum` = 0x00, `cpu_reset` falls 18 cycles after the fall register edge, `rom_ready` = 1, `dl_error` = 0.
- Load only 100 bytes → ERROR, `dl_error` = 1, `cpu_reset` stays at 1. A subsequent full load clears `dl_error` and reaches RUN.
- Index-0 write to address 0x8000 within an otherwise full load → no `rom_we` for it, ERROR, `dl_error` = 1.
- Index-1 writes 0x05 then 0x0A → `tno` = 0x0A, no `rom_we`, the `cnt`-based check is unaffected.
- In RUN, pulse `ext_reset` for 1 cycle → `cpu_reset` high for exactly 16 cycles, `tno` and `chksum` unchanged.
- Assert `reset_n` low mid-load, then release → all outputs at reset values, IDLE, and `ioctl_wr` strobes without a new rise produce no `rom_we`.

Source files
------------

// File: rtl/poly_dl_ctrl.sv
// poly_dl_ctrl: PolyPlay download router and CPU boot/reset sequencer
module poly_dl_ctrl #(
   parameter int ROM_BYTES   = 32768,
   parameter int HOLD_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ext_reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        rom_we,
   output logic [15:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic [7:0]  tno,
   output logic        cpu_reset,
   output logic        rom_ready,
   output logic        dl_error,
   output logic [7:0]  chksum
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_RUN   = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   logic [2:0]    state_q, state_d;
   logic          dl_prev_q, rise_q, fall_q;
   logic [16:0]   cnt_q, cnt_d;
   logic [7:0]    sum_q, sum_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [7:0]    tno_q, tno_d;
   logic          we_q;
   logic [15:0]   addr_q;
   logic [7:0]    data_q;
   logic          wr_ok, idx0, acc;

   // the edge that restarts a load swallows any strobe arriving with it
   assign wr_ok = ioctl_wr & (state_q == S_LOAD) & ~rise_q;
   assign idx0  = wr_ok & (ioctl_index == 8'd0);
   assign acc   = idx0 & (ioctl_addr < 25'(ROM_BYTES));

   // next-state and load bookkeeping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      hold_d  = hold_q;
      tno_d   = tno_q;
      if (rise_q) begin
         state_d = S_LOAD;
         cnt_d   = '0;
         sum_d   = '0;
         ovf_d   = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               cnt_d   = acc ? cnt_q + 17'd1 : cnt_q;
               sum_d   = acc ? sum_q + ioctl_dout : sum_q;
               ovf_d   = ovf_q | (idx0 & ~acc);
               tno_d   = (wr_ok && ioctl_index == 8'd1) ? ioctl_dout : tno_q;
               state_d = fall_q ? S_CHECK : S_LOAD;
            end
            S_CHECK: begin
               err_d   = ovf_q || (cnt_q != 17'(ROM_BYTES));
               state_d = err_d ? S_ERROR : S_HOLD;
               hold_d  = '0;
            end
            S_HOLD: begin
               hold_d  = hold_q + 1'b1;
               state_d = (hold_q == HW'(HOLD_CYCLES - 1)) ? S_RUN : S_HOLD;
            end
            S_RUN: begin
               state_d = ext_reset ? S_HOLD : S_RUN;
               hold_d  = '0;
            end
            S_IDLE, S_ERROR: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // state, edge detect and load registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         dl_prev_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         cnt_q     <= '0;
         sum_q     <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         hold_q    <= '0;
         tno_q     <= '0;
      end else begin
         state_q   <= state_d;
         dl_prev_q <= ioctl_download;
         rise_q    <= ioctl_download & ~dl_prev_q;
         fall_q    <= ~ioctl_download & dl_prev_q;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         hold_q    <= hold_d;
         tno_q     <= tno_d;
      end
   end

   // registered ROM write port, address/data hold their last accepted value
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         we_q   <= acc;
         addr_q <= acc ? ioctl_addr[15:0] : addr_q;
         data_q <= acc ? ioctl_dout : data_q;
      end
   end

   assign rom_we    = we_q;
   assign rom_addr  = addr_q;
   assign rom_data  = data_q;
   assign tno       = tno_q;
   assign chksum    = sum_q;
   assign dl_error  = err_q;
   assign cpu_reset = (state_q != S_RUN);
   assign rom_ready = (state_q == S_RUN);
endmodule

// File: tb/tb_poly_dl_ctrl.sv
// tb_poly_dl_ctrl: directed self-checking bench for poly_dl_ctrl
module tb_poly_dl_ctrl;
   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ext_reset = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        rom_we, cpu_reset, rom_ready, dl_error;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data, tno, chksum;
   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;

   poly_dl_ctrl dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ext_reset(ext_reset),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data), .tno(tno),
      .cpu_reset(cpu_reset), .rom_ready(rom_ready), .dl_error(dl_error),
      .chksum(chksum)
   );

   // free-running clock
   initial forever #5 clk_sys = ~clk_sys;

   // count ROM write pulses mid-cycle
   always @(negedge clk_sys) if (rom_we) we_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      tick();
      tick();
   endtask

   task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1;
      ioctl_index = idx;
      ioctl_addr = a;
      ioctl_dout = d;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic burst(input int n, input bit ovf);
      for (int i = 0; i < n; i++) begin
         ioctl_wr = 1'b1;
         ioctl_index = 8'd0;
         ioctl_addr = 25'(i);
         ioctl_dout = 8'(i);
         tick();
         if (i == 10) begin
            chk("we_pulse", rom_we, 1);
            chk("we_addr", rom_addr, 10);
            chk("we_data", rom_data, 10);
         end
         if (ovf && i == 1000) begin
            ioctl_addr = 25'h8000;
            ioctl_dout = 8'h55;
            tick();
            chk("ovf_no_we", rom_we, 0);
         end
      end
      ioctl_wr = 1'b0;
      tick();
      chk("we_end", rom_we, 0);
   endtask

   initial begin
      int w0;
      int k;
      repeat (3) tick();
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_rom_ready", rom_ready, 0);
      chk("rst_rom_we", rom_we, 0);
      chk("rst_tno", tno, 0);
      chk("rst_chksum", chksum, 0);
      chk("rst_dl_error", dl_error, 0);
      reset_n = 1'b1;
      tick();
      // short load of 100 bytes ends in ERROR
      start_dl();
      w0 = we_cnt;
      burst(100, 1'b0);
      chk("a_we_count", we_cnt - w0, 100);
      chk("a_chksum", chksum, 8'h56);
      ioctl_download = 1'b0;
      repeat (4) tick();
      chk("a_dl_error", dl_error, 1);
      chk("a_cpu_reset", cpu_reset, 1);
      ext_reset = 1'b1;
      tick();
      ext_reset = 1'b0;
      repeat (20) tick();
      chk("a_ext_ignored", cpu_reset, 1);
      chk("a_rom_ready", rom_ready, 0);
      // full load with title writes reaches RUN
      start_dl();
      chk("b_err_cleared", dl_error, 0);
      chk("b_sum_cleared", chksum, 0);
      w0 = we_cnt;
      wr(8'd1, 25'd0, 8'h05);
      chk("tno_first", tno, 8'h05);
      wr(8'd1, 25'd0, 8'h0A);
      tick();
      chk("tno_last", tno, 8'h0A);
      chk("tno_no_we", we_cnt - w0, 0);
      w0 = we_cnt;
      burst(32768, 1'b0);
      chk("b_we_count", we_cnt - w0, 32768);
      ioctl_download = 1'b0;
      tick();
      k = 0;
      while (cpu_reset && k < 40) begin
         tick();
         k++;
      end
      chk("b_boot_latency", k, 18);
      chk("b_rom_ready", rom_ready, 1);
      chk("b_dl_error", dl_error, 0);
      chk("b_chksum", chksum, 8'h00);
      chk("b_tno", tno, 8'h0A);
      // one-cycle external reset in RUN
      ext_reset = 1'b1;
      tick();
      ext_reset = 1'b0;
      k = 0;
      while (cpu_reset && k < 40) begin
         k++;
         tick();
      end
      chk("ext_hold_len", k, 16);
      chk("ext_tno", tno, 8'h0A);
      chk("ext_chksum", chksum, 8'h00);
      chk("ext_rom_ready", rom_ready, 1);
      // full load plus one out-of-range byte ends in ERROR
      start_dl();
      w0 = we_cnt;
      burst(32768, 1'b1);
      chk("c_we_count", we_cnt - w0, 32768);
      chk("c_chksum", chksum, 8'h00);
      ioctl_download = 1'b0;
      repeat (4) tick();
      chk("c_dl_error", dl_error, 1);
      chk("c_cpu_reset", cpu_reset, 1);
      // asynchronous reset in the middle of a load
      start_dl();
      burst(50, 1'b0);
      reset_n = 1'b0;
      ioctl_download = 1'b0;
      #2;
      chk("mid_rom_we", rom_we, 0);
      chk("mid_rom_addr", rom_addr, 0);
      chk("mid_rom_data", rom_data, 0);
      chk("mid_tno", tno, 0);
      chk("mid_chksum", chksum, 0);
      chk("mid_dl_error", dl_error, 0);
      chk("mid_cpu_reset", cpu_reset, 1);
      tick();
      reset_n = 1'b1;
      tick();
      w0 = we_cnt;
      for (int i = 0; i < 5; i++) wr(8'd0, 25'(i), 8'hAA);
      tick();
      chk("post_rst_no_we", we_cnt - w0, 0);
      chk("post_rst_chksum", chksum, 0);
      chk("post_rst_cpu_reset", cpu_reset, 1);
      chk("post_rst_rom_ready", rom_ready, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
